// File: rtl/ifetch.sv
// Instruction fetch front end: issues sequential fetch addresses to the I-cache and buffers returned words.
// Optional macro IFETCH_BYPASS_EN: an empty FIFO forwards a returning word to the core in the same cycle.
module ifetch #(
   parameter logic [23:0] RESET_PC   = 24'h000000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        addr_ready_in,
   output logic        addr_valid_out,
   output logic [23:0] addr_out,
   output logic        data_ready_out,
   input  logic        data_valid_in,
   input  logic [31:0] data_in,
   input  logic        redirect,
   input  logic [23:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [23:0] inst_pc
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;

   logic          run_q;
   logic [23:0]   pc_q, pc_d;
   logic [23:0]   head_pc_q, head_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   mem_q [FIFO_DEPTH];

   logic          addr_hs;
   logic          beat;
   logic          keep_word;
   logic          push;
   logic          pop;
   logic          pop_fifo;
   logic          fifo_empty;
   logic          bypass;
   logic [SW-1:0] credits;
   logic [23:0]   redir_pc;

   assign redir_pc   = {redirect_pc[23:2], 2'b00};
   assign fifo_empty = (count_q == '0);

   // Outstanding requests plus buffered words never exceed the FIFO size,
   // so every response has a slot and the data channel never back-pressures.
   assign credits        = SW'(outst_q) + SW'(count_q);
   assign addr_valid_out = run_q & (credits < SW'(FIFO_DEPTH));
   assign addr_out       = pc_q;
   assign data_ready_out = run_q;
   assign inst_pc        = head_pc_q;

   assign addr_hs   = addr_valid_out & addr_ready_in;
   assign beat      = data_valid_in & data_ready_out;
   assign keep_word = beat & (discard_q == '0) & ~redirect;

`ifdef IFETCH_BYPASS_EN
   assign bypass     = fifo_empty & keep_word;
   assign inst_valid = ~fifo_empty | bypass;
   assign inst       = fifo_empty ? (bypass ? data_in : 32'd0) : mem_q[rd_ptr_q];
   assign pop        = inst_valid & inst_ready & ~redirect;
   assign push       = keep_word & ~(bypass & inst_ready);
`else
   assign bypass     = 1'b0;
   assign inst_valid = ~fifo_empty;
   assign inst       = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
   assign pop        = inst_valid & inst_ready & ~redirect;
   assign push       = keep_word;
`endif
   assign pop_fifo = pop & ~bypass;

   always_comb begin
      pc_d      = pc_q;
      head_pc_d = head_pc_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      discard_d = discard_q;
      outst_d   = outst_q + CW'(addr_hs) - CW'(beat);
      count_d   = count_q + CW'(push) - CW'(pop_fifo);
      if (addr_hs) begin
         pc_d = pc_q + 24'd4;
      end
      if (beat && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_fifo) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (pop) begin
         head_pc_d = head_pc_q + 24'd4;
      end
      // Everything still in flight after this cycle belongs to the old stream.
      if (redirect) begin
         pc_d      = redir_pc;
         head_pc_d = redir_pc;
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         discard_d = outst_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q     <= 1'b0;
         pc_q      <= RESET_PC;
         head_pc_q <= RESET_PC;
         count_q   <= '0;
         outst_q   <= '0;
         discard_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         run_q     <= 1'b1;
         pc_q      <= pc_d;
         head_pc_q <= head_pc_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a latency-varying cache model and an instruction-stream reference model.
module tb_ifetch;
   localparam int          DEPTH = 4;
   localparam logic [23:0] RPC   = 24'h000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        addr_ready_in, addr_valid_out, data_ready_out, data_valid_in;
   logic [23:0] addr_out, redirect_pc, inst_pc;
   logic [31:0] data_in, inst;
   logic        redirect, inst_valid, inst_ready;

   ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .addr_ready_in(addr_ready_in), .addr_valid_out(addr_valid_out), .addr_out(addr_out),
      .data_ready_out(data_ready_out), .data_valid_in(data_valid_in), .data_in(data_in),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] addr;
      int          gen;
      int          t;
   } req_t;

   req_t        cq[$];       // requests accepted by the cache, oldest first
   logic [23:0] mf[$];       // addresses of words the core should see next
   logic [23:0] exp_pc, exp_head;
   int          gen, cyc, pop_cnt;
   int          n_checks = 0, n_err = 0;
   int          p_addr, p_inst, p_dv, p_redir, lat_min, lat_max;
   bit          force_req, force_hb;
   int          force_outst;
   logic [23:0] force_pc;

   function automatic logic [31:0] word_of(input logic [23:0] a);
      return {~a[7:0], a};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cq.delete();
      mf.delete();
      gen++;
      exp_pc   = RPC;
      exp_head = RPC;
   endtask

   task automatic step();
      logic        hs, beat, pop, rd;
      logic [23:0] rpc;
      req_t        r;
      @(negedge clk);
      check("inst_valid", 32'(inst_valid), 32'(mf.size() != 0));
      check("inst_pc", 32'(inst_pc), 32'(exp_head));
      if (mf.size() != 0) check("inst", inst, word_of(mf[0]));
      check("addr_valid", 32'(addr_valid_out), 32'((cq.size() + mf.size()) < DEPTH));
      check("addr_out", 32'(addr_out), 32'(exp_pc));
      check("data_ready", 32'(data_ready_out), 32'd1);

      addr_ready_in = ($urandom_range(99) < p_addr);
      inst_ready    = ($urandom_range(99) < p_inst);
      if (cq.size() != 0 && cq[0].t <= cyc && $urandom_range(99) < p_dv) begin
         data_valid_in = 1'b1;
         data_in       = word_of(cq[0].addr);
      end else begin
         data_valid_in = 1'b0;
         data_in       = $urandom;
      end
      hs   = addr_valid_out & addr_ready_in;
      beat = data_valid_in & data_ready_out;
      pop  = inst_valid & inst_ready;
      rd   = 1'b0;
      rpc  = 24'($urandom);
      if (force_req) begin
         if ((force_outst < 0 || cq.size() == force_outst) && (!force_hb || (hs && beat))) begin
            rd        = 1'b1;
            rpc       = force_pc;
            force_req = 1'b0;
         end
      end else if ($urandom_range(999) < p_redir) begin
         rd = 1'b1;
      end
      redirect    = rd;
      redirect_pc = rpc;

      if (hs) begin
         r.addr = exp_pc;
         r.gen  = gen;
         r.t    = cyc + $urandom_range(lat_max, lat_min);
         cq.push_back(r);
         exp_pc += 24'd4;
      end
      if (beat) begin
         r = cq.pop_front();
         if (r.gen == gen) mf.push_back(r.addr);
      end
      if (pop) begin
         void'(mf.pop_front());
         exp_head += 24'd4;
         pop_cnt++;
      end
      if (rd) begin
         mf.delete();
         gen++;
         exp_pc   = {rpc[23:2], 2'b00};
         exp_head = {rpc[23:2], 2'b00};
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic forced_redirect(input logic [23:0] pc, input int outst, input bit hb);
      force_pc    = pc;
      force_outst = outst;
      force_hb    = hb;
      force_req   = 1'b1;
      for (int i = 0; i < 300 && force_req; i++) step();
      if (force_req) begin
         check("redirect_window", 32'd0, 32'd1);
         force_req = 1'b0;
      end
      $display("redirect to %h issued (cycle %0d)", pc, cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr_valid"}, 32'(addr_valid_out), 32'd0);
      check({tag, "_addr_out"}, 32'(addr_out), 32'(RPC));
      check({tag, "_data_ready"}, 32'(data_ready_out), 32'd0);
      check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      check({tag, "_inst"}, inst, 32'd0);
      check({tag, "_inst_pc"}, 32'(inst_pc), 32'(RPC));
   endtask

   initial begin
      rst = 1'b0;
      addr_ready_in = 1'b0; data_valid_in = 1'b0; data_in = '0;
      redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      gen = 0; cyc = 0; pop_cnt = 0; force_req = 1'b0; force_hb = 1'b0; force_outst = -1;
      force_pc = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk);

      // Streaming with a fixed 2-cycle memory and an always-ready core.
      p_addr = 100; p_inst = 100; p_dv = 100; p_redir = 0; lat_min = 2; lat_max = 2;
      run(10);
      pop_cnt = 0;
      run(20);
      check("throughput", 32'(pop_cnt), 32'd20);
      $display("streaming phase done: %0d pops in 20 cycles", pop_cnt);

      // Core stalled: issue must stop at the credit limit with nothing lost.
      p_inst = 0;
      run(20);
      #1 check("stall_addr_valid", 32'(addr_valid_out), 32'd0);
      check("stall_inst_valid", 32'(inst_valid), 32'd1);
      $display("stall phase done");
      p_inst = 100;
      run(10);

      // Redirects: with two outstanding, and coinciding with a handshake and a beat.
      lat_min = 1; lat_max = 3; p_dv = 70;
      forced_redirect(24'h000103, 2, 1'b0);
      run(15);
      forced_redirect(24'h000240, -1, 1'b1);
      run(15);
      p_dv = 100;
      forced_redirect(24'hFFFFF8, -1, 1'b0);
      run(20);

      // Reset mid-burst.
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      data_valid_in = 1'b0; redirect = 1'b0;
      #1 check_reset_outputs("midreset");
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      run(20);
      $display("mid-burst reset phase done");

      // Fully random traffic with occasional redirects.
      p_addr = 70; p_inst = 60; p_dv = 60; p_redir = 20; lat_min = 1; lat_max = 6;
      run(3000);
      p_addr = 100; p_inst = 30; p_dv = 100; p_redir = 5; lat_min = 1; lat_max = 2;
      run(1000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
